conv_mac_array: RTL

Pipelined, multi-channel convolution MAC array that is the successor to the single-window convolution unit. The array multiplies one CONV_SIZE-tap input window against KERNEL_NUM kernels per beat and accumulates the sums over CHANNEL_NUM consecutive beats, one beat per input channel. It then emits one saturated fixed-point result per kernel. It sits between the line-buffer/window generator and the activation/pooling stage, and carries valid/ready handshakes on both sides.

---
 rtl/conv_mac_array.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/conv_mac_array.sv
// Four-stage multi-channel convolution MAC array: multiply, floor-shift, tree-sum, accumulate, saturate.
// Optional build macro CONV_MAC_RELU_EN zeroes negative saturated lanes.
module conv_mac_array #(
    parameter int CONV_SIZE      = 9,
    parameter int KERNEL_NUM     = 4,
    parameter int CHANNEL_NUM    = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int FRACTION_WIDTH = 15
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [DATA_WIDTH-1:0] i_input_feature [0:CONV_SIZE-1],
    input  logic signed [DATA_WIDTH-1:0] i_kernel [0:KERNEL_NUM-1][0:CONV_SIZE-1],
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [DATA_WIDTH-1:0] o_result [0:KERNEL_NUM-1],
    output logic                         o_overflow
);
    localparam int PROD_WIDTH  = 2 * DATA_WIDTH;
    localparam int SHIFT_WIDTH = 2 * DATA_WIDTH - FRACTION_WIDTH;
    localparam int ACC_WIDTH   = SHIFT_WIDTH + $clog2(CONV_SIZE * CHANNEL_NUM);
    localparam int CNT_WIDTH   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    // Handshakes: a beat moves when valid && ready on the same rising edge; a result
    // held with o_valid && !i_ready freezes the whole pipeline and blocks new beats.
    logic stall;
    logic accept;
    logic in_first;
    logic in_last;

    logic [CNT_WIDTH-1:0] chan_q, chan_d;

    logic                         s1_valid_q, s1_first_q, s1_last_q;
    logic signed [DATA_WIDTH-1:0] s1_feat_q [0:CONV_SIZE-1];
    logic signed [DATA_WIDTH-1:0] s1_kern_q [0:KERNEL_NUM-1][0:CONV_SIZE-1];

    logic                          s2_valid_q, s2_first_q, s2_last_q;
    logic signed [SHIFT_WIDTH-1:0] s2_prod_q [0:KERNEL_NUM-1][0:CONV_SIZE-1];
    logic signed [SHIFT_WIDTH-1:0] s2_prod_d [0:KERNEL_NUM-1][0:CONV_SIZE-1];

    logic                        s3_valid_q, s3_first_q, s3_last_q;
    logic signed [ACC_WIDTH-1:0] s3_sum_q [0:KERNEL_NUM-1];
    logic signed [ACC_WIDTH-1:0] s3_sum_d [0:KERNEL_NUM-1];

    logic signed [ACC_WIDTH-1:0]  acc_q [0:KERNEL_NUM-1];
    logic signed [ACC_WIDTH-1:0]  acc_d [0:KERNEL_NUM-1];
    logic signed [DATA_WIDTH-1:0] sat_d [0:KERNEL_NUM-1];
    logic signed [DATA_WIDTH-1:0] result_q [0:KERNEL_NUM-1];
    logic [KERNEL_NUM-1:0]        clamp;
    logic                         load_out;
    logic                         out_valid_q;
    logic                         ovf_q;

    assign stall    = out_valid_q && !i_ready;
    assign o_ready  = !stall && !i_reset;
    assign accept   = i_valid && o_ready;
    assign in_first = (chan_q == '0);
    assign in_last  = (chan_q == CNT_WIDTH'(CHANNEL_NUM - 1));

    assign o_valid    = out_valid_q;
    assign o_overflow = ovf_q;
    assign o_result   = result_q;

    always_comb begin
        chan_d = chan_q;
        if (accept) begin
            chan_d = in_last ? '0 : chan_q + CNT_WIDTH'(1);
        end
    end

    // Full-width product, then arithmetic shift gives floor rounding toward -inf.
    always_comb begin
        logic signed [PROD_WIDTH-1:0] prod;
        logic signed [PROD_WIDTH-1:0] shifted;
        prod    = '0;
        shifted = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            for (int t = 0; t < CONV_SIZE; t++) begin
                prod    = PROD_WIDTH'(s1_feat_q[t]) * PROD_WIDTH'(s1_kern_q[k][t]);
                shifted = prod >>> FRACTION_WIDTH;
                s2_prod_d[k][t] = shifted[SHIFT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < KERNEL_NUM; k++) begin
            s3_sum_d[k] = '0;
            for (int t = 0; t < CONV_SIZE; t++) begin
                s3_sum_d[k] = s3_sum_d[k] + ACC_WIDTH'(s2_prod_q[k][t]);
            end
        end
    end

    // A lane fits in DATA_WIDTH only if every bit above the result sign matches it.
    always_comb begin
        load_out = s3_valid_q && s3_last_q;
        clamp    = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            acc_d[k] = acc_q[k];
            if (s3_valid_q) begin
                acc_d[k] = s3_first_q ? s3_sum_q[k] : acc_q[k] + s3_sum_q[k];
            end
            clamp[k] = (acc_d[k][ACC_WIDTH-1:DATA_WIDTH-1] !=
                        {(ACC_WIDTH-DATA_WIDTH+1){acc_d[k][ACC_WIDTH-1]}});
            if (clamp[k]) begin
                sat_d[k] = acc_d[k][ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                sat_d[k] = acc_d[k][DATA_WIDTH-1:0];
            end
`ifdef CONV_MAC_RELU_EN
            if (sat_d[k][DATA_WIDTH-1]) begin
                sat_d[k] = '0;
            end
`endif
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            chan_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_valid_q  <= 1'b0;
            s3_first_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < KERNEL_NUM; k++) begin
                acc_q[k]    <= '0;
                result_q[k] <= '0;
            end
        end else if (!stall) begin
            chan_q      <= chan_d;
            s1_valid_q  <= accept;
            s1_first_q  <= in_first;
            s1_last_q   <= in_last;
            s2_valid_q  <= s1_valid_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
            s3_valid_q  <= s2_valid_q;
            s3_first_q  <= s2_first_q;
            s3_last_q   <= s2_last_q;
            out_valid_q <= load_out;
            for (int k = 0; k < KERNEL_NUM; k++) begin
                acc_q[k] <= acc_d[k];
            end
            if (load_out) begin
                ovf_q <= |clamp;
                for (int k = 0; k < KERNEL_NUM; k++) begin
                    result_q[k] <= sat_d[k];
                end
            end
        end
    end

    // Datapath registers carry no reset; the valid tags alone qualify them.
    always_ff @(posedge i_clock) begin
        if (!stall) begin
            if (accept) begin
                s1_feat_q <= i_input_feature;
                s1_kern_q <= i_kernel;
            end
            s2_prod_q <= s2_prod_d;
            s3_sum_q  <= s3_sum_d;
        end
    end
endmodule
